// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers for the async FIFO pointer crossings.
// Functions work on a 32-bit container; callers pass the live width and truncate.
package gray_pkg;

  localparam int GRAY_PTR_W = 4;
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] width_mask(input int w);
    logic [GRAY_MAX_W-1:0] m;
    if (w >= GRAY_MAX_W) begin
      m = '1;
    end else begin
      m = (32'd1 << w) - 32'd1;
    end
    return m;
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus; plain register chain, nothing between stages.
// Shared by the read- and write-side pointer receivers.
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receives a remote Gray pointer, resynchronises and decodes it, and reports
// per-sample advance, occupancy against the local pointer, and oversize jumps.
module gray_ptr_receiver
  import gray_pkg::*;
#(
  parameter int W           = GRAY_PTR_W,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic [W-1:0] local_bin,
  input  logic         err_clr,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] step,
  output logic         changed,
  output logic [W-1:0] occupancy,
  output logic         err,
  output logic         err_sticky
);

  localparam logic [31:0] LP_MAX_STEP = MAX_STEP[31:0];

  logic [W-1:0] w_gs;
  logic [W-1:0] w_nb;
  logic [W-1:0] w_step;
  logic [W-1:0] w_occ;
  logic         w_changed;
  logic         w_err;
  logic         w_sticky;

  logic [W-1:0] r_bin;
  logic [W-1:0] r_step;
  logic         r_changed;
  logic [W-1:0] r_occ;
  logic         r_err;
  logic         r_sticky;

  gray_sync #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (gray_in),
    .o_q     (w_gs)
  );

  // Subtractions wrap at W bits, so 15 -> 0 reads as a single step.
  always_comb begin
    w_nb      = W'(gray2bin(32'(w_gs), W));
    w_step    = w_nb - r_bin;
    w_changed = (w_nb != r_bin);
    w_occ     = w_nb - local_bin;
    w_err     = (32'(w_step) > LP_MAX_STEP);
    w_sticky  = w_err | r_err | (r_sticky & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_step    <= '0;
      r_changed <= 1'b0;
      r_occ     <= '0;
      r_err     <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_bin     <= w_nb;
      r_step    <= w_step;
      r_changed <= w_changed;
      r_occ     <= w_occ;
      r_err     <= w_err;
      r_sticky  <= w_sticky;
    end
  end

  assign bin_out    = r_bin;
  assign step       = r_step;
  assign changed    = r_changed;
  assign occupancy  = r_occ;
  assign err        = r_err;
  assign err_sticky = r_sticky;

endmodule
